// File: rtl/freq_ascii_tx_if.sv
// Byte-stream bundle between the frequency meter, the ASCII formatter and the Ethernet TX path.
// master = formatter side (consumes freq, drives the byte stream); slave = the surrounding logic.
interface freq_ascii_tx_if #(
  parameter int DROP_W = 16
);
  logic [31:0]       freq;
  logic              freq_vld;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    input  freq, freq_vld, tx_ready,
    output tx_data, tx_valid, tx_last, busy, drop_cnt
  );

  modport slave (
    output freq, freq_vld, tx_ready,
    input  tx_data, tx_valid, tx_last, busy, drop_cnt
  );
endinterface

// File: rtl/freq_ascii_tx.sv
// Converts each freq result to a 12-byte ASCII record (10 digits, CR, LF) on a valid/ready byte stream.
// 33 cycles from accepted sample to first byte; results arriving while busy are counted and dropped. FREQ_AVG_EN: 4-sample mean.
module freq_ascii_tx #(
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter int DROP_W         = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  freq_ascii_tx_if.master bus
);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  state_t            state_q;
  logic [31:0]       bin_q;
  logic [39:0]       bcd_q;
  logic [4:0]        cnt_q;
  logic [3:0]        idx_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              tx_last_q;
  logic              busy_q;
  logic [DROP_W-1:0] drop_q;

  logic              cand_vld;
  logic [31:0]       cand_val;

`ifdef FREQ_AVG_EN
  logic [33:0] acc_q;
  logic [33:0] acc_d;
  logic [1:0]  smp_q;

  always_comb begin
    acc_d    = acc_q + {2'b00, bus.freq};
    cand_vld = bus.freq_vld && (smp_q == 2'd3);
    cand_val = acc_d[33:2];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      acc_q <= '0;
      smp_q <= '0;
    end else if (bus.freq_vld) begin
      acc_q <= (smp_q == 2'd3) ? '0 : acc_d;
      smp_q <= smp_q + 2'd1;
    end
  end
`else
  always_comb begin
    cand_vld = bus.freq_vld;
    cand_val = bus.freq;
  end
`endif

  // One double-dabble step: correct nibbles >= 5, then shift {bcd,bin} left by one.
  function automatic logic [71:0] dabble_step(input logic [39:0] bcd, input logic [31:0] bin);
    logic [39:0] adj;
    adj = '0;
    for (int n = 0; n < 10; n++) begin
      adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end
    return {adj[38:0], bin, 1'b0};
  endfunction

  // Byte idx of the record; a digit is a leading zero when it and every higher digit are zero.
  function automatic logic [7:0] ascii_byte(input logic [39:0] bcd, input logic [3:0] idx);
    logic [5:0]  sh;
    logic [39:0] upper;
    logic        lead;
    if (idx == 4'd10) return 8'h0D;
    if (idx == 4'd11) return 8'h0A;
    sh    = 6'd36 - {idx, 2'b00};
    upper = bcd >> sh;
    lead  = (upper == 40'd0) && (idx != 4'd9);
    if (SUPPRESS_ZEROS && lead) return 8'h20;
    return {4'h3, upper[3:0]};
  endfunction

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (cand_vld && (state_q != IDLE) && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cand_vld) begin
            bin_q   <= cand_val;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= dabble_step(bcd_q, bin_q);
          cnt_q          <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          // First SEND cycle only loads byte 0 from the finished BCD value.
          if (!tx_valid_q) begin
            tx_data_q  <= ascii_byte(bcd_q, idx_q);
            tx_last_q  <= 1'b0;
            tx_valid_q <= 1'b1;
          end else if (bus.tx_ready) begin
            if (tx_last_q) begin
              tx_data_q  <= 8'h00;
              tx_last_q  <= 1'b0;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              idx_q     <= idx_q + 4'd1;
              tx_data_q <= ascii_byte(bcd_q, idx_q + 4'd1);
              tx_last_q <= (idx_q == 4'd10);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_last  = tx_last_q;
  assign bus.busy     = busy_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_freq_ascii_tx.sv
// Directed bench for freq_ascii_tx: a decimal-formatting model predicts every record byte, drop count and start cycle.
// A second instance (no zero suppression, 3-bit drop counter) shares the stimulus to cover padding and saturation.
module tb_freq_ascii_tx;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  freq_ascii_tx_if #(.DROP_W(16)) bus_a ();
  freq_ascii_tx_if #(.DROP_W(3))  bus_b ();

  freq_ascii_tx #(.SUPPRESS_ZEROS(1'b1), .DROP_W(16)) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus_a)
  );

  freq_ascii_tx #(.SUPPRESS_ZEROS(1'b0), .DROP_W(3)) u_dut_nz (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus_b)
  );

  assign bus_b.freq     = bus_a.freq;
  assign bus_b.freq_vld = bus_a.freq_vld;
  assign bus_b.tx_ready = 1'b1;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t   exp_a[$];
  exp_t   exp_b[$];
  int     start_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  int     drop_m = 0;
  longint acc_m  = 0;
  int     n_m    = 0;
  bit     rnd_ready = 1'b0;

  localparam logic [79:0] L_100M = " 100000000";
  localparam logic [79:0] L_ZERO = "         0";
  localparam logic [79:0] L_MAX  = "4294967295";
  localparam logic [79:0] L_SEV  = "0000000007";
  localparam logic [79:0] L_12345 = "     12345";
  localparam logic [79:0] L_25   = "        25";

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk) begin
    #1;
    bus_a.tx_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal rendering straight from the value: digit = (v / 10^pos) % 10.
  function automatic logic [7:0] exp_byte(input logic [31:0] v, input bit sz, input int i);
    longint p = 1;
    longint q;
    if (i == 10) return 8'h0D;
    if (i == 11) return 8'h0A;
    for (int j = 0; j < 9 - i; j++) p = p * 10;
    q = longint'(v) / p;
    if (sz && q == 0 && i < 9) return 8'h20;
    return 8'h30 + 8'(q % 10);
  endfunction

  function automatic logic [79:0] rec_word(input logic [31:0] v, input bit sz);
    logic [79:0] r = '0;
    for (int i = 0; i < 10; i++) r = {r[71:0], exp_byte(v, sz, i)};
    return r;
  endfunction

  task automatic push_record(input logic [31:0] v);
    for (int i = 0; i < 12; i++) begin
      exp_a.push_back('{exp_byte(v, 1'b1, i), i == 11});
      exp_b.push_back('{exp_byte(v, 1'b0, i), i == 11});
    end
    start_q.push_back(cyc + 33);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // One freq_vld strobe; idle says whether the bench expects the DUT to be in IDLE at that edge.
  task automatic pulse(input logic [31:0] v, input bit idle);
    bit          cand;
    logic [31:0] val;
    bus_a.freq     = v;
    bus_a.freq_vld = 1'b1;
    @(posedge sys_clk);
    #1;
    bus_a.freq_vld = 1'b0;
`ifdef FREQ_AVG_EN
    acc_m += longint'(v);
    n_m++;
    cand = (n_m == 4);
    val  = 32'(acc_m >> 2);
    if (cand) begin
      acc_m = 0;
      n_m   = 0;
    end
`else
    cand = 1'b1;
    val  = v;
`endif
    if (cand) begin
      if (idle) push_record(val);
      else drop_m++;
    end
  endtask

  task automatic submit(input logic [31:0] v);
`ifdef FREQ_AVG_EN
    repeat (4) pulse(v, 1'b1);
`else
    pulse(v, 1'b1);
`endif
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 3000) begin
      @(posedge sys_clk);
      #1;
      t++;
    end
    if (t >= 3000) chk("record_timeout", 80'(exp_a.size() + exp_b.size()), 80'd0);
    @(negedge sys_clk);
    chk("busy_after_record", bus_a.busy, 1'b0);
    chk("valid_after_record", bus_a.tx_valid, 1'b0);
    chk("busy_after_record_nz", bus_b.busy, 1'b0);
    @(posedge sys_clk);
    #1;
  endtask

  logic       prev_vld_a   = 1'b0;
  logic       prev_stall_a = 1'b0;
  logic [7:0] prev_dat_a   = 8'h00;
  logic       prev_last_a  = 1'b0;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_vld_a   <= 1'b0;
      prev_stall_a <= 1'b0;
    end else begin
      if (bus_a.tx_valid) begin
        if (exp_a.size() == 0) begin
          chk("valid_without_record", bus_a.tx_valid, 1'b0);
        end else begin
          if (!prev_vld_a && start_q.size() > 0) chk("first_byte_latency", 80'(cyc), 80'(start_q.pop_front()));
          chk("tx_data", bus_a.tx_data, exp_a[0].b);
          chk("tx_last", bus_a.tx_last, exp_a[0].last);
          chk("busy_while_valid", bus_a.busy, 1'b1);
          if (prev_stall_a) begin
            chk("stall_data_stable", bus_a.tx_data, prev_dat_a);
            chk("stall_last_stable", bus_a.tx_last, prev_last_a);
          end
          if (bus_a.tx_ready) void'(exp_a.pop_front());
        end
      end
      prev_vld_a   <= bus_a.tx_valid;
      prev_stall_a <= bus_a.tx_valid && !bus_a.tx_ready;
      prev_dat_a   <= bus_a.tx_data;
      prev_last_a  <= bus_a.tx_last;
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n && bus_b.tx_valid) begin
      if (exp_b.size() == 0) begin
        chk("valid_without_record_nz", bus_b.tx_valid, 1'b0);
      end else begin
        chk("tx_data_nz", bus_b.tx_data, exp_b[0].b);
        chk("tx_last_nz", bus_b.tx_last, exp_b[0].last);
        void'(exp_b.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bus_a.freq     = '0;
    bus_a.freq_vld = 1'b0;
    sys_rst_n      = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_tx_data", bus_a.tx_data, 8'h00);
    chk("rst_tx_valid", bus_a.tx_valid, 1'b0);
    chk("rst_tx_last", bus_a.tx_last, 1'b0);
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_drop_cnt", bus_a.drop_cnt, 16'd0);
    chk("rst_drop_cnt_nz", bus_b.drop_cnt, 3'd0);

    chk("model_100M", rec_word(32'd100_000_000, 1'b1), L_100M);
    chk("model_zero", rec_word(32'd0, 1'b1), L_ZERO);
    chk("model_max", rec_word(32'hFFFF_FFFF, 1'b1), L_MAX);
    chk("model_seven_nz", rec_word(32'd7, 1'b0), L_SEV);
    chk("model_12345", rec_word(32'd12345, 1'b1), L_12345);
    chk("model_avg25", rec_word(32'd25, 1'b1), L_25);

    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    wait_edges(2);

    submit(32'd100_000_000);
    wait_done();
    submit(32'd0);
    wait_done();
    submit(32'hFFFF_FFFF);
    wait_done();
    submit(32'd7);
    wait_done();

    rnd_ready = 1'b1;
    submit(32'd123_456_789);
    wait_done();
    submit(32'd1000);
    wait_done();
    rnd_ready = 1'b0;
    wait_edges(2);

    chk("drop_before", bus_a.drop_cnt, 80'(drop_m));
    submit(32'd55555);
    wait_edges(4);
    pulse(32'd999, 1'b0);
    wait_edges(39);
    pulse(32'd888, 1'b0);
    wait_done();
    chk("drop_after", bus_a.drop_cnt, 80'(drop_m));
`ifdef FREQ_AVG_EN
    chk("drop_after_lit", bus_a.drop_cnt, 16'd0);
    pulse(32'd0, 1'b1);
    pulse(32'd0, 1'b1);
    wait_done();
`else
    chk("drop_after_lit", bus_a.drop_cnt, 16'd2);
`endif

    submit(32'd54321);
    wait_edges(37);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    exp_a.delete();
    exp_b.delete();
    start_q.delete();
    acc_m  = 0;
    n_m    = 0;
    drop_m = 0;
    chk("midsend_rst_valid", bus_a.tx_valid, 1'b0);
    chk("midsend_rst_busy", bus_a.busy, 1'b0);
    chk("midsend_rst_drop", bus_a.drop_cnt, 16'd0);
    chk("midsend_rst_valid_nz", bus_b.tx_valid, 1'b0);
    wait_edges(1);
    submit(32'd12345);
    wait_done();

    submit(32'd4242);
`ifdef FREQ_AVG_EN
    for (int j = 0; j < 36; j++) begin
`else
    for (int j = 0; j < 9; j++) begin
`endif
      pulse(32'(j), 1'b0);
      chk("drop_cnt_track", bus_a.drop_cnt, 80'(drop_m));
      chk("drop_cnt_sat_nz", bus_b.drop_cnt, 80'((drop_m > 7) ? 7 : drop_m));
    end
    wait_done();
    chk("drop_sat_nz_lit", bus_b.drop_cnt, 3'd7);

`ifdef FREQ_AVG_EN
    pulse(32'd10, 1'b1);
    pulse(32'd20, 1'b1);
    pulse(32'd30, 1'b1);
    pulse(32'd41, 1'b1);
    wait_done();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
